// File: rtl/load_issue_queue_pkg.sv
// Shared widths and default sizing for the load issue queue.
// lq_entry_t is the queue entry layout at the default widths.
package load_issue_queue_pkg;

  localparam int unsigned LQ_DEPTH    = 8;
  localparam int unsigned LQ_PREG_W   = 6;
  localparam int unsigned LQ_ROB_W    = 5;
  localparam int unsigned LQ_OFF_W    = 16;
  localparam int unsigned LQ_NUM_WAKE = 2;

  typedef struct packed {
    logic                 valid;
    logic                 base_rdy;
    logic [LQ_ROB_W-1:0]  rob;
    logic [LQ_PREG_W-1:0] base_tag;
    logic [LQ_PREG_W-1:0] dst_tag;
    logic [LQ_OFF_W-1:0]  offset;
  } lq_entry_t;

endpackage

// File: rtl/load_issue_queue_age_matrix.sv
// DEPTH x DEPTH relative-age tracker with oldest-requester grant.
// Bit [i][j]=1 means entry i is older than entry j.
module load_issue_queue_age_matrix #(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] free_oh,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);

  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic [DEPTH-1:0] blocked;

  // Free wins over alloc so a slot issued this cycle never keeps a stale ordering bit.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        age_d[i][j] = age_q[i][j];
        if (i == j) begin
          age_d[i][j] = 1'b0;
        end else if (clear || free_oh[i] || free_oh[j] || alloc_oh[i]) begin
          age_d[i][j] = 1'b0;
        end else if (alloc_oh[j]) begin
          age_d[i][j] = valid[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q <= '{default: '0};
    end else begin
      age_q <= age_d;
    end
  end

  // A requester is blocked if any older entry is also requesting.
  always_comb begin
    blocked = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (req[i] && age_q[i][j]) begin
          blocked[j] = 1'b1;
        end
      end
    end
    grant = req & ~blocked;
  end

endmodule

// File: rtl/load_issue_queue.sv
// Out-of-order load issue queue: tag wakeup, oldest-ready select, full flush.
module load_issue_queue
  import load_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = LQ_DEPTH,
  parameter int unsigned PREG_W   = LQ_PREG_W,
  parameter int unsigned ROB_W    = LQ_ROB_W,
  parameter int unsigned OFF_W    = LQ_OFF_W,
  parameter int unsigned NUM_WAKE = LQ_NUM_WAKE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [ROB_W-1:0]             alloc_rob,
  input  logic [PREG_W-1:0]            alloc_base_tag,
  input  logic                         alloc_base_rdy,
  input  logic [PREG_W-1:0]            alloc_dst_tag,
  input  logic [OFF_W-1:0]             alloc_offset,
  input  logic [NUM_WAKE-1:0]          wake_valid,
  input  logic [NUM_WAKE*PREG_W-1:0]   wake_tag,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [ROB_W-1:0]             issue_rob,
  output logic [PREG_W-1:0]            issue_base_tag,
  output logic [PREG_W-1:0]            issue_dst_tag,
  output logic [OFF_W-1:0]             issue_offset,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  base_rdy_q;
  logic [ROB_W-1:0]  rob_q      [DEPTH];
  logic [PREG_W-1:0] base_tag_q [DEPTH];
  logic [PREG_W-1:0] dst_tag_q  [DEPTH];
  logic [OFF_W-1:0]  offset_q   [DEPTH];
  logic [CNT_W-1:0]  count_q;

  logic [DEPTH-1:0] wake_hit;
  logic             alloc_wake_hit;
  logic [DEPTH-1:0] free_slot_oh;
  logic             free_found;
  logic [DEPTH-1:0] alloc_oh;
  logic [DEPTH-1:0] issue_oh;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] grant;
  logic             alloc_fire;
  logic             issue_fire;

  assign alloc_ready = (count_q < CNT_W'(DEPTH));
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign ready_vec   = valid_q & base_rdy_q;
  assign issue_valid = |ready_vec;
  assign issue_fire  = issue_valid && issue_ready && !flush;
  assign alloc_oh    = alloc_fire ? free_slot_oh : '0;
  assign issue_oh    = issue_fire ? grant : '0;
  assign count       = count_q;
  assign empty       = (count_q == '0);

  // Wakeup CAM, including same-cycle bypass for the allocating load.
  always_comb begin
    wake_hit       = '0;
    alloc_wake_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_WAKE; k++) begin
      if (wake_valid[k] && (wake_tag[k*PREG_W +: PREG_W] == alloc_base_tag)) begin
        alloc_wake_hit = 1'b1;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wake_valid[k] && (wake_tag[k*PREG_W +: PREG_W] == base_tag_q[i])) begin
          wake_hit[i] = 1'b1;
        end
      end
    end
  end

  // Lowest-index invalid slot.
  always_comb begin
    free_slot_oh = '0;
    free_found   = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_slot_oh[i] = 1'b1;
        free_found      = 1'b1;
      end
    end
  end

  load_issue_queue_age_matrix #(
    .DEPTH (DEPTH)
  ) u_age_matrix (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .valid    (valid_q),
    .alloc_oh (alloc_oh),
    .free_oh  (issue_oh),
    .req      (ready_vec),
    .grant    (grant)
  );

  // One-hot grant mux; all-zero fields when nothing is ready.
  always_comb begin
    issue_rob      = '0;
    issue_base_tag = '0;
    issue_dst_tag  = '0;
    issue_offset   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        issue_rob      = issue_rob      | rob_q[i];
        issue_base_tag = issue_base_tag | base_tag_q[i];
        issue_dst_tag  = issue_dst_tag  | dst_tag_q[i];
        issue_offset   = issue_offset   | offset_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      base_rdy_q <= '0;
      count_q    <= '0;
    end else if (flush) begin
      valid_q    <= '0;
      base_rdy_q <= '0;
      count_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alloc_oh[i]) begin
          valid_q[i]    <= 1'b1;
          base_rdy_q[i] <= alloc_base_rdy || alloc_wake_hit;
        end else if (issue_oh[i]) begin
          valid_q[i]    <= 1'b0;
          base_rdy_q[i] <= 1'b0;
        end else if (valid_q[i] && wake_hit[i]) begin
          base_rdy_q[i] <= 1'b1;
        end
      end
      count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
    end
  end

  // Payload needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alloc_oh[i]) begin
        rob_q[i]      <= alloc_rob;
        base_tag_q[i] <= alloc_base_tag;
        dst_tag_q[i]  <= alloc_dst_tag;
        offset_q[i]   <= alloc_offset;
      end
    end
  end

endmodule
